// File: rtl/lif_pkg.sv
// Shared types and codes for the LIF per-timestep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, datapath mux codes, and a helper that maps
// a state to the datapath mux code driven while in that state.
package lif_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAK  = 3'd1,
        INTEG = 3'd2,
        CHECK = 3'd3,
        FIRE  = 3'd4,
        SKIP  = 3'd5
    } lif_state_e;

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_LEAK  = 2'd1;
    localparam logic [1:0] SEL_INPUT = 2'd2;

    // Only the two Vm-update phases steer the datapath; everything else holds.
    function automatic logic [1:0] mux_for_state(input logic [2:0] s);
        logic [1:0] sel;
        sel = SEL_HOLD;
        if (s == 3'(LEAK))  sel = SEL_LEAK;
        if (s == 3'(INTEG)) sel = SEL_INPUT;
        return sel;
    endfunction

endpackage

// File: rtl/lif_step_sequencer_if.sv
// Bundle between timestep scheduler / neuron datapath and the LIF sequencer.
// Latency: n/a (wires only).
// Backpressure: step is only honoured while busy=0; otherwise it is flagged via overrun.
//
// Signals:
//   step, ge_thresh, ovr_clr                 driven by the master (scheduler/datapath side)
//   vm_load, vm_init, mux_sel, spike_out,
//   busy, done, refrac, overrun              driven by the slave (sequencer)
//   spike_count (SCNT_W)                     slave output, present only with LIF_SPIKE_CNT_EN
interface lif_step_sequencer_if
`ifdef LIF_SPIKE_CNT_EN
#(
    parameter int SCNT_W = 8
)
`endif
;
    logic       step;
    logic       ge_thresh;
    logic       ovr_clr;
    logic       vm_load;
    logic       vm_init;
    logic [1:0] mux_sel;
    logic       spike_out;
    logic       busy;
    logic       done;
    logic       refrac;
    logic       overrun;
`ifdef LIF_SPIKE_CNT_EN
    logic [SCNT_W-1:0] spike_count;
`endif

    modport master (
        output step, ge_thresh, ovr_clr,
        input  vm_load, vm_init, mux_sel, spike_out, busy, done, refrac, overrun
`ifdef LIF_SPIKE_CNT_EN
        , input spike_count
`endif
    );

    modport slave (
        input  step, ge_thresh, ovr_clr,
        output vm_load, vm_init, mux_sel, spike_out, busy, done, refrac, overrun
`ifdef LIF_SPIKE_CNT_EN
        , output spike_count
`endif
    );

endinterface

// File: rtl/lif_refrac_counter.sv
// Refractory down-counter: loaded on a spike, decremented once per skipped step.
// Latency: load/dec take effect at the next clk edge; zero follows the register directly.
// Backpressure: none; load wins over dec, dec at zero is ignored (never wraps).
//
// Ports: clk, rst (sync, active-high), load, load_val[RCNT_W], dec, zero.
module lif_refrac_counter #(
    parameter int RCNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [RCNT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [RCNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - RCNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lif_step_sequencer.sv
// Per-timestep LIF neuron controller: leak, integrate, threshold check, fire / refractory skip.
// Latency from step accept edge t0: done at t0+3 (no spike), t0+4 with spike, t0+1 when refractory.
// Backpressure: busy=1 outside IDLE; a step seen while busy is dropped and sets sticky overrun.
//
// Ports: clk, rst (sync, active-high), bus (lif_step_sequencer_if.slave).
// Optional feature macro LIF_SPIKE_CNT_EN adds the saturating spike_count output (SCNT_W bits).
//
// Output timing: vm_load/mux_sel are registered from the next state, so they are
// visible during LEAK and INTEG themselves and Vm is updated before CHECK compares it.
// done/spike_out/vm_init are registered on leaving CHECK/FIRE/SKIP, i.e. they pulse in
// the first IDLE cycle, which is why a new step can be accepted right on the done cycle.
module lif_step_sequencer
    import lif_pkg::*;
#(
    parameter int REFRAC_STEPS = 2,
    parameter int RCNT_W       = 4
`ifdef LIF_SPIKE_CNT_EN
    , parameter int SCNT_W     = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    lif_step_sequencer_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_LEAK  = 3'(LEAK);
    localparam logic [2:0] S_INTEG = 3'(INTEG);
    localparam logic [2:0] S_CHECK = 3'(CHECK);
    localparam logic [2:0] S_FIRE  = 3'(FIRE);
    localparam logic [2:0] S_SKIP  = 3'(SKIP);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       cnt_zero;

    logic       vm_load_q;
    logic       vm_init_q;
    logic [1:0] mux_sel_q;
    logic       spike_q;
    logic       busy_q;
    logic       done_q;
    logic       overrun_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.step) state_nxt = cnt_zero ? S_LEAK : S_SKIP;
            S_LEAK:  state_nxt = S_INTEG;
            S_INTEG: state_nxt = S_CHECK;
            S_CHECK: state_nxt = bus.ge_thresh ? S_FIRE : S_IDLE;
            S_FIRE:  state_nxt = S_IDLE;
            S_SKIP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            vm_load_q <= 1'b0;
            vm_init_q <= 1'b0;
            mux_sel_q <= SEL_HOLD;
            spike_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            vm_load_q <= (state_nxt == S_LEAK) || (state_nxt == S_INTEG);
            mux_sel_q <= mux_for_state(state_nxt);
            busy_q    <= (state_nxt != S_IDLE);
            spike_q   <= (state == S_FIRE);
            vm_init_q <= (state == S_FIRE);
            done_q    <= ((state == S_CHECK) && !bus.ge_thresh) ||
                         (state == S_FIRE) || (state == S_SKIP);
        end
    end

    // A late step while busy takes priority over a simultaneous clear so it is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (bus.step && (state != S_IDLE)) begin
            overrun_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    lif_refrac_counter #(
        .RCNT_W   (RCNT_W)
    ) u_refrac (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_FIRE),
        .load_val (RCNT_W'(REFRAC_STEPS)),
        .dec      (state == S_SKIP),
        .zero     (cnt_zero)
    );

`ifdef LIF_SPIKE_CNT_EN
    logic [SCNT_W-1:0] spike_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_cnt <= '0;
        end else if ((state == S_FIRE) && (spike_cnt != '1)) begin
            spike_cnt <= spike_cnt + SCNT_W'(1);
        end
    end

    assign bus.spike_count = spike_cnt;
`endif

    assign bus.vm_load   = vm_load_q;
    assign bus.vm_init   = vm_init_q;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.spike_out = spike_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.refrac    = !cnt_zero;
    assign bus.overrun   = overrun_q;

endmodule
